// File: rtl/eda_region_scan_ctrl_if.sv
// Bus between the region-scan sequencer and the pixel-compare / output-RAM side.
// rd_req is a one-cycle request; the comparator answers later with a one-cycle cmp_valid.
interface eda_region_scan_ctrl_if #(
  parameter int M       = 4,
  parameter int N       = 4,
  parameter int I_WIDTH = 2,
  parameter int J_WIDTH = 2
);
  // Handshake: each rd_req pulse is answered by exactly one cmp_valid pulse, which may
  // arrive any number of cycles later; the sequencer holds center/nbr stable until then
  // and ignores cmp_valid whenever it has no request outstanding.
  logic                     start;
  logic                     busy;
  logic                     done;
  logic [I_WIDTH-1:0]       center_i;
  logic [J_WIDTH-1:0]       center_j;
  logic [I_WIDTH-1:0]       nbr_i;
  logic [J_WIDTH-1:0]       nbr_j;
  logic                     rd_req;
  logic                     cmp_valid;
  logic                     clear;
  logic                     new_pixel;
  logic                     update_strb;
  logic                     iterated_all;
  logic [M-1:0][N-1:0]      strb_value;

  modport master (
    input  start, cmp_valid,
    output busy, done, center_i, center_j, nbr_i, nbr_j, rd_req,
           clear, new_pixel, update_strb, iterated_all, strb_value
  );

  modport slave (
    output start, cmp_valid,
    input  busy, done, center_i, center_j, nbr_i, nbr_j, rd_req,
           clear, new_pixel, update_strb, iterated_all, strb_value
  );
endinterface

// File: rtl/eda_region_scan_ctrl.sv
// Raster sequencer for the regional-maximum output RAM: visits every centre pixel and
// every in-bounds window neighbour, issuing one compare request per neighbour.
`ifndef CFG_M
`define CFG_M 4
`endif
`ifndef CFG_N
`define CFG_N 4
`endif
`ifndef CFG_WINDOW_WIDTH
`define CFG_WINDOW_WIDTH 3
`endif
`ifndef CFG_I_WIDTH
`define CFG_I_WIDTH 2
`endif
`ifndef CFG_J_WIDTH
`define CFG_J_WIDTH 2
`endif

module eda_region_scan_ctrl #(
  parameter int M            = `CFG_M,
  parameter int N            = `CFG_N,
  parameter int WINDOW_WIDTH = `CFG_WINDOW_WIDTH,
  parameter int I_WIDTH      = `CFG_I_WIDTH,
  parameter int J_WIDTH      = `CFG_J_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  eda_region_scan_ctrl_if.master bus,
  output logic [2:0]            state_dbg
);
  localparam int R  = WINDOW_WIDTH / 2;
  localparam int IW = I_WIDTH + 1;
  localparam int JW = J_WIDTH + 1;

  localparam logic signed [IW-1:0] R_I    = IW'(R);
  localparam logic signed [JW-1:0] R_J    = JW'(R);
  localparam logic signed [IW-1:0] MAX_I  = IW'(M - 1);
  localparam logic signed [JW-1:0] MAX_J  = JW'(N - 1);
  localparam logic signed [IW-1:0] ONE_I  = IW'(1);
  localparam logic signed [JW-1:0] ONE_J  = JW'(1);
  localparam logic [I_WIDTH-1:0]   LAST_CI = I_WIDTH'(M - 1);
  localparam logic [J_WIDTH-1:0]   LAST_CJ = J_WIDTH'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_SCAN, S_REQ, S_WAIT, S_NEXTC, S_FIN
  } state_t;

  state_t state, state_nxt;

  logic [I_WIDTH-1:0]     ci, ni;
  logic [J_WIDTH-1:0]     cj, nj;
  logic signed [IW-1:0]   di, ci_s, ti, rem_i, dmi, last_di, di_adv;
  logic signed [JW-1:0]   dj, cj_s, tj, rem_j, dmj, last_dj, dj_adv;
  logic                   iter_all;
  logic                   off_valid, off_final, is_last, last_ctr, np;

  // Overflow of ci+di past the top of the signed range wraps negative, which the
  // sign test rejects just as the true (too large) coordinate would be.
  always_comb begin
    ci_s      = $signed({1'b0, ci});
    cj_s      = $signed({1'b0, cj});
    ti        = ci_s + di;
    tj        = cj_s + dj;
    off_valid = !ti[IW-1] && (ti <= MAX_I) && !tj[JW-1] && (tj <= MAX_J)
                && !((di == '0) && (dj == '0));
    off_final = (di == R_I) && (dj == R_J);
    last_ctr  = (ci == LAST_CI) && (cj == LAST_CJ);

    rem_i = MAX_I - ci_s;
    rem_j = MAX_J - cj_s;
    dmi   = (rem_i < R_I) ? rem_i : R_I;
    dmj   = (rem_j < R_J) ? rem_j : R_J;
    // The window's far corner is the centre itself on the bottom-right pixel; then the
    // last neighbour is the one just before it in raster order.
    if ((dmi != '0) || (dmj != '0)) begin
      last_di = dmi;
      last_dj = dmj;
    end else if (cj != '0) begin
      last_di = '0;
      last_dj = '1;
    end else begin
      last_di = '1;
      last_dj = '0;
    end
    is_last = (di == last_di) && (dj == last_dj);

    if (dj == R_J) begin
      di_adv = di + ONE_I;
      dj_adv = -R_J;
    end else begin
      di_adv = di;
      dj_adv = dj + ONE_J;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.start) state_nxt = S_CLEAR;
      S_CLEAR: state_nxt = S_SCAN;
      S_SCAN: begin
        if (off_valid)      state_nxt = S_REQ;
        else if (off_final) state_nxt = S_NEXTC;
      end
      S_REQ:   state_nxt = S_WAIT;
      S_WAIT:  if (bus.cmp_valid) state_nxt = is_last ? S_NEXTC : S_SCAN;
      S_NEXTC: state_nxt = last_ctr ? S_FIN : S_SCAN;
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    np              = (state == S_WAIT) && bus.cmp_valid;
    bus.busy        = (state != S_IDLE);
    bus.done        = (state == S_FIN);
    bus.clear       = (state == S_CLEAR);
    bus.rd_req      = (state == S_REQ);
    bus.new_pixel   = np;
    bus.update_strb = np && is_last;
    bus.strb_value  = '0;
    for (int i = 0; i < M; i++) begin
      for (int j = 0; j < N; j++) begin
        bus.strb_value[i][j] = (state != S_IDLE) && (ci == I_WIDTH'(i)) && (cj == J_WIDTH'(j));
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ci       <= '0;
      cj       <= '0;
      ni       <= '0;
      nj       <= '0;
      di       <= '0;
      dj       <= '0;
      iter_all <= 1'b1;
    end else begin
      case (state)
        S_CLEAR: begin
          ci       <= '0;
          cj       <= '0;
          di       <= -R_I;
          dj       <= -R_J;
          iter_all <= 1'b0;
        end
        S_SCAN: begin
          if (off_valid) begin
            ni <= ti[I_WIDTH-1:0];
            nj <= tj[J_WIDTH-1:0];
          end else if (!off_final) begin
            di <= di_adv;
            dj <= dj_adv;
          end
        end
        S_WAIT: begin
          if (bus.cmp_valid && !is_last) begin
            di <= di_adv;
            dj <= dj_adv;
          end
        end
        S_NEXTC: begin
          if (last_ctr) begin
            iter_all <= 1'b1;
          end else begin
            di <= -R_I;
            dj <= -R_J;
            if (cj == LAST_CJ) begin
              cj <= '0;
              ci <= ci + 1'b1;
            end else begin
              cj <= cj + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.center_i     = ci;
  assign bus.center_j     = cj;
  assign bus.nbr_i        = ni;
  assign bus.nbr_j        = nj;
  assign bus.iterated_all = iter_all;
  assign state_dbg        = state;
endmodule

// File: tb/tb_eda_region_scan_ctrl.sv
// Bench for eda_region_scan_ctrl: a 4x4/3x3 instance checked every cycle against a
// neighbour-list model, plus a 1x1 instance for the degenerate image.
module tb_eda_region_scan_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [2:0] state_dbg4, state_dbg1;

  always #5 clk = ~clk;

  eda_region_scan_ctrl_if #(.M(4), .N(4), .I_WIDTH(2), .J_WIDTH(2)) bus4 ();
  eda_region_scan_ctrl_if #(.M(1), .N(1), .I_WIDTH(1), .J_WIDTH(1)) bus1 ();

  eda_region_scan_ctrl #(.M(4), .N(4), .WINDOW_WIDTH(3), .I_WIDTH(2), .J_WIDTH(2)) u_dut4 (
    .clk(clk), .reset(reset), .bus(bus4), .state_dbg(state_dbg4)
  );
  eda_region_scan_ctrl #(.M(1), .N(1), .WINDOW_WIDTH(3), .I_WIDTH(1), .J_WIDTH(1)) u_dut1 (
    .clk(clk), .reset(reset), .bus(bus1), .state_dbg(state_dbg1)
  );

  // Expected request list: {last, ci, cj, ni, nj} with 4-bit fields.
  logic [16:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int rd_cnt = 0, np_cnt = 0, us_cnt = 0, clr_cnt = 0, done_cnt = 0;
  int k = 0;
  bit mpend = 0;
  bit chk_en = 0;
  bit rand_mode = 0;
  bit rp = 0;
  int rcnt = 0;
  logic [16:0] e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void build_model();
    int first;
    exp_q.delete();
    for (int ci = 0; ci < 4; ci++) begin
      for (int cj = 0; cj < 4; cj++) begin
        first = exp_q.size();
        for (int di = -1; di <= 1; di++) begin
          for (int dj = -1; dj <= 1; dj++) begin
            if (!(di == 0 && dj == 0) && ci + di >= 0 && ci + di < 4 && cj + dj >= 0 && cj + dj < 4)
              exp_q.push_back({1'b0, 4'(ci), 4'(cj), 4'(ci + di), 4'(cj + dj)});
          end
        end
        if (exp_q.size() > first) exp_q[exp_q.size() - 1][16] = 1'b1;
      end
    end
  endfunction

  function automatic logic [63:0] onehot4(input logic [16:0] x);
    return 64'd1 << (int'(x[15:12]) * 4 + int'(x[11:8]));
  endfunction

  // Comparator stand-in: answers each rd_req after a delay, optionally with noise.
  always @(posedge clk) begin
    #1;
    if (reset) begin
      rp = 0;
      bus4.cmp_valid = 1'b0;
    end else begin
      if (rp) begin
        if (rcnt == 0) begin
          bus4.cmp_valid = 1'b1;
          rp = 0;
        end else begin
          bus4.cmp_valid = 1'b0;
          rcnt--;
        end
      end else begin
        bus4.cmp_valid = rand_mode && ($urandom_range(0, 3) == 0);
      end
      if (bus4.rd_req) begin
        rp = 1;
        rcnt = rand_mode ? int'($urandom_range(0, 7)) : 0;
      end
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      k = 0;
      mpend = 0;
    end else if (chk_en) begin
      if (bus4.clear) begin
        clr_cnt++;
        check("clear_at_start", k, 0);
      end
      if (bus4.new_pixel) np_cnt++;
      if (bus4.update_strb) us_cnt++;
      if (mpend) begin
        e = exp_q[k];
        check("wait_rd_req", bus4.rd_req, 0);
        check("wait_center_i", bus4.center_i, e[15:12]);
        check("wait_center_j", bus4.center_j, e[11:8]);
        check("wait_nbr_i", bus4.nbr_i, e[7:4]);
        check("wait_nbr_j", bus4.nbr_j, e[3:0]);
        check("wait_strb", bus4.strb_value, onehot4(e));
        check("wait_busy", bus4.busy, 1);
        check("wait_iter_all", bus4.iterated_all, 0);
        check("new_pixel", bus4.new_pixel, bus4.cmp_valid);
        check("update_strb", bus4.update_strb, bus4.cmp_valid & e[16]);
        if (bus4.cmp_valid) begin
          mpend = 0;
          k++;
        end
      end else begin
        check("stray_new_pixel", bus4.new_pixel, 0);
        check("stray_update_strb", bus4.update_strb, 0);
      end
      if (bus4.rd_req) begin
        rd_cnt++;
        if (k < exp_q.size()) begin
          e = exp_q[k];
          check("req_center_i", bus4.center_i, e[15:12]);
          check("req_center_j", bus4.center_j, e[11:8]);
          check("req_nbr_i", bus4.nbr_i, e[7:4]);
          check("req_nbr_j", bus4.nbr_j, e[3:0]);
          check("req_strb", bus4.strb_value, onehot4(e));
          mpend = 1;
        end else begin
          check("req_overrun", k, exp_q.size() - 1);
        end
      end
      if (bus4.done) begin
        done_cnt++;
        check("done_all_served", k, exp_q.size());
        check("done_iter_all", bus4.iterated_all, 1);
        k = 0;
      end
      if (!bus4.busy) check("idle_strb", bus4.strb_value, 0);
    end
  end

  task automatic run_scan(input bit inject);
    int r0, n0, u0, c0, d0;
    bit got;
    r0 = rd_cnt; n0 = np_cnt; u0 = us_cnt; c0 = clr_cnt; d0 = done_cnt;
    @(posedge clk); #2 bus4.start = 1'b1;
    @(posedge clk); #2 bus4.start = 1'b0;
    got = 0;
    for (int cyc = 0; cyc < 3000 && !got; cyc++) begin
      @(negedge clk);
      if (inject && cyc == 40) bus4.start = 1'b1;
      if (inject && cyc == 41) bus4.start = 1'b0;
      if (bus4.done) got = 1;
    end
    check("scan_timeout", got, 1);
    @(negedge clk); #1;
    check("after_busy", bus4.busy, 0);
    check("after_iter_all", bus4.iterated_all, 1);
    repeat (20) @(negedge clk);
    #1;
    check("rd_req_count", rd_cnt - r0, 84);
    check("new_pixel_count", np_cnt - n0, 84);
    check("update_strb_count", us_cnt - u0, 16);
    check("clear_count", clr_cnt - c0, 1);
    check("done_count", done_cnt - d0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bit found, got;
    int c1, r1, n1, d1, lasts;
    bus4.start = 1'b0;
    bus4.cmp_valid = 1'b0;
    bus1.start = 1'b0;
    bus1.cmp_valid = 1'b0;

    build_model();
    lasts = 0;
    foreach (exp_q[i]) lasts += int'(exp_q[i][16]);
    check("model_size", exp_q.size(), 84);
    check("model_lasts", lasts, 16);
    check("model_c00_a", exp_q[0], {1'b0, 4'd0, 4'd0, 4'd0, 4'd1});
    check("model_c00_b", exp_q[1], {1'b0, 4'd0, 4'd0, 4'd1, 4'd0});
    check("model_c00_c", exp_q[2], {1'b1, 4'd0, 4'd0, 4'd1, 4'd1});
    check("model_c33_a", exp_q[81], {1'b0, 4'd3, 4'd3, 4'd2, 4'd2});
    check("model_c33_b", exp_q[82], {1'b0, 4'd3, 4'd3, 4'd2, 4'd3});
    check("model_c33_c", exp_q[83], {1'b1, 4'd3, 4'd3, 4'd3, 4'd2});

    repeat (3) @(negedge clk);
    check("rst_busy", bus4.busy, 0);
    check("rst_done", bus4.done, 0);
    check("rst_iter_all", bus4.iterated_all, 1);
    check("rst_strb", bus4.strb_value, 0);
    check("rst_center", {bus4.center_i, bus4.center_j, bus4.nbr_i, bus4.nbr_j}, 0);
    check("rst_strobes", {bus4.rd_req, bus4.clear, bus4.new_pixel, bus4.update_strb}, 0);
    check("rst1_iter_all", bus1.iterated_all, 1);
    check("rst1_busy", bus1.busy, 0);
    @(posedge clk); #3 reset = 1'b0;
    chk_en = 1;

    rand_mode = 0;
    run_scan(1'b1);
    rand_mode = 1;
    run_scan(1'b0);

    // Abort in the middle of centre (2,1).
    @(posedge clk); #2 bus4.start = 1'b1;
    @(posedge clk); #2 bus4.start = 1'b0;
    found = 0;
    for (int cyc = 0; cyc < 3000 && !found; cyc++) begin
      @(negedge clk);
      if (bus4.rd_req && bus4.center_i == 2'd2 && bus4.center_j == 2'd1) found = 1;
    end
    check("reach_center_21", found, 1);
    @(posedge clk); #2 reset = 1'b1;
    @(negedge clk);
    check("abort_busy", bus4.busy, 0);
    check("abort_iter_all", bus4.iterated_all, 1);
    check("abort_strobes", {bus4.rd_req, bus4.clear, bus4.done, bus4.new_pixel}, 0);
    check("abort_strb", bus4.strb_value, 0);
    @(posedge clk); #3 reset = 1'b0;
    run_scan(1'b0);

    // Degenerate 1x1 image: no neighbours at all.
    c1 = 0; r1 = 0; n1 = 0; d1 = 0;
    @(posedge clk); #2 bus1.start = 1'b1;
    @(posedge clk); #2 bus1.start = 1'b0;
    got = 0;
    for (int cyc = 0; cyc < 100 && !got; cyc++) begin
      @(negedge clk);
      if (bus1.clear) c1++;
      if (bus1.rd_req) r1++;
      if (bus1.new_pixel) n1++;
      if (bus1.busy) check("one_strb", bus1.strb_value, 1);
      if (bus1.done) begin
        d1++;
        got = 1;
        check("one_done_iter_all", bus1.iterated_all, 1);
      end
      bus1.cmp_valid = 1'($urandom_range(0, 1));
    end
    bus1.cmp_valid = 1'b0;
    check("one_timeout", got, 1);
    check("one_clear_count", c1, 1);
    check("one_rd_req_count", r1, 0);
    check("one_new_pixel_count", n1, 0);
    check("one_done_count", d1, 1);
    @(negedge clk);
    check("one_after_busy", bus1.busy, 0);
    check("one_after_iter_all", bus1.iterated_all, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/eda_region_scan_ctrl.md
Name: eda_region_scan_ctrl

Overview:
- Sequencer for the regional-maximum output RAM.
- Walks every centre pixel of the M×N image in raster order. For each centre it walks every in-bounds neighbour of the WINDOW_WIDTH×WINDOW_WIDTH window.
- For each neighbour it requests a pixel-pair read and comparison, then drives clear / new_pixel / update_strb / iterated_all / strb_value to the output RAM, so each centre's flag becomes the AND of all its neighbour comparisons.

Parameters:
- M, `CFG_M: image rows
- N, `CFG_N: image columns
- WINDOW_WIDTH, `CFG_WINDOW_WIDTH: odd window size; radius R = WINDOW_WIDTH/2
- I_WIDTH, `CFG_I_WIDTH: row index width, ≥ clog2(M)
- J_WIDTH, `CFG_J_WIDTH: column index width, ≥ clog2(N)

Ports:
- clk, input, 1: clock
- reset, input, 1: asynchronous reset, active-high
- start, input, 1: begin scan of a newly loaded image; ignored unless idle
- busy, output, 1: high from the cycle after accepted start until the done cycle inclusive
- done, output, 1: one-cycle pulse when the scan completes
- center_i, output, I_WIDTH: current centre row
- center_j, output, J_WIDTH: current centre column
- nbr_i, output, I_WIDTH: current neighbour row
- nbr_j, output, J_WIDTH: current neighbour column
- rd_req, output, 1: one-cycle request to fetch/compare (center, nbr)
- cmp_valid, input, 1: comparator result (compare_out) valid this cycle
- clear, output, 1: one-cycle matrix clear to output RAM
- new_pixel, output, 1: neighbour result commit strobe
- update_strb, output, 1: last neighbour of the current centre
- iterated_all, output, 1: all centres done
- strb_value, output, [M-1:0][N-1:0]: one-hot at (center_i, center_j), zero otherwise

Behaviour:
- Reset: state IDLE; all outputs 0 except iterated_all = 1; indices 0; strb_value all 0.
- FSM states: IDLE, CLEAR, SCAN, REQ, WAIT, NEXTC, FIN.
- IDLE: on start go to CLEAR.
- CLEAR: assert clear for 1 cycle; centre = (0,0), offset = (-R,-R); iterated_all → 0; go to SCAN.
- SCAN: 1 cycle per candidate offset (di,dj), raster order di = -R..R, dj = -R..R.
  - Candidate is valid iff (di,dj) ≠ (0,0) and 0 ≤ ci+di < M and 0 ≤ cj+dj < N.
  - Valid: latch nbr = (ci+di, cj+dj) and go to REQ.
  - Invalid and not the final offset (R,R): advance the offset and stay in SCAN.
  - Offset (R,R) invalid: go to NEXTC.
- REQ: rd_req = 1 for exactly one cycle, then WAIT.
- WAIT: hold nbr and centre stable; wait any number of cycles for cmp_valid.
  - new_pixel = cmp_valid, combinational in WAIT only, so it aligns with the comparator's compare_out.
  - update_strb = new_pixel & is_last.
  - is_last: nbr is the highest raster-order valid offset of this centre, i.e. di = min(R, M-1-ci) and dj = min(R, N-1-cj). When that pair is (0,0), use the previous valid offset in raster order.
  - After cmp_valid: if is_last, go to NEXTC; else advance the offset and go to SCAN.
- NEXTC: advance centre raster (cj+1, wrap to 0 with ci+1); reset offset to (-R,-R); go to SCAN.
  - If the centre was (M-1, N-1): set iterated_all = 1 and go to FIN.
- A centre with no valid neighbour (M = N = 1) gets no new_pixel. Its flag stays 1 from clear.
- FIN: done = 1 for one cycle, then IDLE. iterated_all stays 1 until the next CLEAR.
- strb_value is driven every non-IDLE cycle as a one-hot of the centre.
- cmp_valid outside WAIT is ignored and causes no new_pixel.
- start while busy is ignored.
- Reset mid-scan returns to the reset values immediately, with no clear pulse. The next start re-clears.
- All index arithmetic is done signed, one bit wider than I_WIDTH/J_WIDTH, for the bounds check. Outputs are truncated to I_WIDTH/J_WIDTH.

Test Plan:
- M=N=4, WINDOW_WIDTH=3, cmp_valid 1 cycle after each rd_req → exactly 84 rd_req and 84 new_pixel, 16 update_strb, one clear at start, one done. iterated_all = 1 after done.
- Same config, centre (0,0) → neighbours in order (0,1), (1,0), (1,1). update_strb only with (1,1). strb_value = one-hot bit [0][0].
- Centre (3,3) → neighbours (2,2), (2,3), (3,2). update_strb with (3,2), the previous-valid rule.
- Random cmp_valid delay 0–7 cycles plus spurious cmp_valid in SCAN/REQ → new_pixel count still 84. nbr stable throughout each WAIT.
- Assert reset during WAIT of centre (2,1) → next cycle: IDLE, busy = 0, iterated_all = 1. A new start gives a clear pulse and restarts from (0,0) with 84 requests.
- M=N=1 → clear, no rd_req, no new_pixel, done, iterated_all = 1. start pulsed while busy (4×4 run) → ignored, single done.
